// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register feeding the ALU. It captures decoded
//            operands and control from ID, holds them on stall and inserts a
//            bubble on flush. It also forwards from MEM and WB onto the
//            captured rs/rt values.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            stall, flush          - hazard-unit hold / bubble requests
//            *_d                   - ID-stage instruction, operands, control
//            m_we/m_waddr/m_wdata  - MEM-stage producer (forward source 1)
//            w_we/w_waddr/w_wdata  - WB-stage producer (forward source 2)
//            *_e, rs_out, rt_out,
//            imm_ext               - registered EX-stage fields / ALU inputs
//            valid_e               - 1 = real instruction, 0 = bubble
//            fwd_sel_rs/rt         - 0 none, 1 MEM, 2 WB
//            bubble_cnt            - flush counter (IDEX_BUBBLE_CNT_EN only)
// Options  : define IDEX_BUBBLE_CNT_EN to add the 32-bit bubble_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic [31:0]   ins_d,
   input  logic [31:0]   pc4_d,
   input  logic [DW-1:0] rs_d,
   input  logic [DW-1:0] rt_d,
   input  logic [DW-1:0] imm_ext_d,
   input  logic [2:0]    aluop_d,
   input  logic          sll_slt_d,
   input  logic          alusrc_d,
   input  logic          regwrite_d,
   input  logic          memtoreg_d,
   input  logic          memwrite_d,
   input  logic [RW-1:0] waddr_d,
   input  logic          m_we,
   input  logic [RW-1:0] m_waddr,
   input  logic [DW-1:0] m_wdata,
   input  logic          w_we,
   input  logic [RW-1:0] w_waddr,
   input  logic [DW-1:0] w_wdata,
   output logic [31:0]   ins_e,
   output logic [31:0]   pc4_e,
   output logic [DW-1:0] rs_out,
   output logic [DW-1:0] rt_out,
   output logic [DW-1:0] imm_ext,
   output logic [2:0]    aluop_e,
   output logic          sll_slt_e,
   output logic          alusrc_e,
   output logic          regwrite_e,
   output logic          memtoreg_e,
   output logic          memwrite_e,
   output logic [RW-1:0] waddr_e,
   output logic          valid_e,
`ifdef IDEX_BUBBLE_CNT_EN
   output logic [31:0]   bubble_cnt,
`endif
   output logic [1:0]    fwd_sel_rs,
   output logic [1:0]    fwd_sel_rt
);

   localparam logic [RW-1:0] c_zero_addr = '0;
   localparam logic [1:0]    c_sel_none  = 2'd0;
   localparam logic [1:0]    c_sel_mem   = 2'd1;
   localparam logic [1:0]    c_sel_wb    = 2'd2;

   logic [31:0]   r_ins;
   logic [31:0]   r_pc4;
   logic [DW-1:0] r_rs;
   logic [DW-1:0] r_rt;
   logic [DW-1:0] r_imm;
   logic [2:0]    r_aluop;
   logic          r_sll_slt;
   logic          r_alusrc;
   logic          r_regwrite;
   logic          r_memtoreg;
   logic          r_memwrite;
   logic [RW-1:0] r_waddr;
   logic          r_valid;

   logic [RW-1:0] w_rs_addr;
   logic [RW-1:0] w_rt_addr;
   logic [DW-1:0] w_rs_fwd;
   logic [DW-1:0] w_rt_fwd;
   logic [1:0]    w_sel_rs;
   logic [1:0]    w_sel_rt;

   assign w_rs_addr = RW'(r_ins[25:21]);
   assign w_rt_addr = RW'(r_ins[20:16]);

   // MEM is the younger producer, so it beats WB; $0 is hard-wired zero and
   // must never pick up a forwarded value.
   always_comb begin
      w_rs_fwd = r_rs;
      w_sel_rs = c_sel_none;
      if (m_we && (m_waddr == w_rs_addr) && (w_rs_addr != c_zero_addr)) begin
         w_rs_fwd = m_wdata;
         w_sel_rs = c_sel_mem;
      end else if (w_we && (w_waddr == w_rs_addr) && (w_rs_addr != c_zero_addr)) begin
         w_rs_fwd = w_wdata;
         w_sel_rs = c_sel_wb;
      end
   end

   always_comb begin
      w_rt_fwd = r_rt;
      w_sel_rt = c_sel_none;
      if (m_we && (m_waddr == w_rt_addr) && (w_rt_addr != c_zero_addr)) begin
         w_rt_fwd = m_wdata;
         w_sel_rt = c_sel_mem;
      end else if (w_we && (w_waddr == w_rt_addr) && (w_rt_addr != c_zero_addr)) begin
         w_rt_fwd = w_wdata;
         w_sel_rt = c_sel_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_ins      <= '0;
         r_pc4      <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_imm      <= '0;
         r_aluop    <= '0;
         r_sll_slt  <= 1'b0;
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_memwrite <= 1'b0;
         r_waddr    <= '0;
         r_valid    <= 1'b0;
      end else if (stall) begin
         // Re-capture the forwarded operands so a producer retiring from WB
         // while we are held does not take its result with it.
         r_rs <= w_rs_fwd;
         r_rt <= w_rt_fwd;
      end else begin
         r_ins      <= ins_d;
         r_pc4      <= pc4_d;
         r_rs       <= rs_d;
         r_rt       <= rt_d;
         r_imm      <= imm_ext_d;
         r_aluop    <= aluop_d;
         r_sll_slt  <= sll_slt_d;
         r_alusrc   <= alusrc_d;
         r_regwrite <= regwrite_d;
         r_memtoreg <= memtoreg_d;
         r_memwrite <= memwrite_d;
         r_waddr    <= waddr_d;
         r_valid    <= 1'b1;
      end
   end

`ifdef IDEX_BUBBLE_CNT_EN
   logic [31:0] r_bubble_cnt;

   // Counts every inserted bubble, including a flush that overrides a stall;
   // wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= '0;
      end else if (flush) begin
         r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
`endif

   assign ins_e      = r_ins;
   assign pc4_e      = r_pc4;
   assign rs_out     = w_rs_fwd;
   assign rt_out     = w_rt_fwd;
   assign imm_ext    = r_imm;
   assign aluop_e    = r_aluop;
   assign sll_slt_e  = r_sll_slt;
   assign alusrc_e   = r_alusrc;
   assign regwrite_e = r_regwrite;
   assign memtoreg_e = r_memtoreg;
   assign memwrite_e = r_memwrite;
   assign waddr_e    = r_waddr;
   assign valid_e    = r_valid;
   assign fwd_sel_rs = w_sel_rs;
   assign fwd_sel_rt = w_sel_rt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. Expected EX-stage contents
//            are queued when ID stimulus is driven and compared after the
//            capturing edge; forwarding is checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc4;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [2:0]  aluop;
      logic [5:0]  ctrl;   // {sll_slt, alusrc, regwrite, memtoreg, memwrite, valid}
      logic [4:0]  waddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [31:0] ins_d, pc4_d, rs_d, rt_d, imm_ext_d;
   logic [2:0]  aluop_d;
   logic        sll_slt_d, alusrc_d, regwrite_d, memtoreg_d, memwrite_d;
   logic [4:0]  waddr_d;
   logic        m_we, w_we;
   logic [4:0]  m_waddr, w_waddr;
   logic [31:0] m_wdata, w_wdata;
   logic [31:0] ins_e, pc4_e, rs_out, rt_out, imm_ext;
   logic [2:0]  aluop_e;
   logic        sll_slt_e, alusrc_e, regwrite_e, memtoreg_e, memwrite_e, valid_e;
   logic [4:0]  waddr_e;
   logic [1:0]  fwd_sel_rs, fwd_sel_rt;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e_exp, e_obs;
   localparam exp_t c_bubble = '0;

   id_ex_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .ins_d(ins_d), .pc4_d(pc4_d), .rs_d(rs_d), .rt_d(rt_d),
      .imm_ext_d(imm_ext_d), .aluop_d(aluop_d), .sll_slt_d(sll_slt_d),
      .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
      .memwrite_d(memwrite_d), .waddr_d(waddr_d),
      .m_we(m_we), .m_waddr(m_waddr), .m_wdata(m_wdata),
      .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
      .ins_e(ins_e), .pc4_e(pc4_e), .rs_out(rs_out), .rt_out(rt_out),
      .imm_ext(imm_ext), .aluop_e(aluop_e), .sll_slt_e(sll_slt_e),
      .alusrc_e(alusrc_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
      .memwrite_e(memwrite_e), .waddr_e(waddr_e), .valid_e(valid_e),
`ifdef IDEX_BUBBLE_CNT_EN
      .bubble_cnt(bubble_cnt),
`endif
      .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(input logic [31:0] ins, pc4, rs, rt, imm,
                               input logic [2:0] op, input logic [4:0] c5,
                               input logic [4:0] wa);
      exp_t e;
      e.ins = ins; e.pc4 = pc4; e.rs = rs; e.rt = rt; e.imm = imm;
      e.aluop = op; e.ctrl = {c5, 1'b1}; e.waddr = wa;
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t e;
      e.ins = ins_e; e.pc4 = pc4_e; e.rs = rs_out; e.rt = rt_out; e.imm = imm_ext;
      e.aluop = aluop_e;
      e.ctrl = {sll_slt_e, alusrc_e, regwrite_e, memtoreg_e, memwrite_e, valid_e};
      e.waddr = waddr_e;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      w_we = 1'b0; w_waddr = '0; w_wdata = '0;
   endtask

   task automatic drive_load(input exp_t e);
      ins_d = e.ins; pc4_d = e.pc4; rs_d = e.rs; rt_d = e.rt; imm_ext_d = e.imm;
      aluop_d = e.aluop;
      {sll_slt_d, alusrc_d, regwrite_d, memtoreg_d, memwrite_d} = e.ctrl[5:1];
      waddr_d = e.waddr;
      sb.push_back(e);
   endtask

   task automatic drive_rand();
      ins_d = $urandom; pc4_d = $urandom; rs_d = $urandom; rt_d = $urandom;
      imm_ext_d = $urandom; aluop_d = 3'($urandom_range(0, 5));
      {sll_slt_d, alusrc_d, regwrite_d, memtoreg_d, memwrite_d} = 5'b11111;
      waddr_d = 5'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      clear_fwd();
      for (int i = 0; i < 2; i++) begin
         drive_rand();
         sb.push_back(c_bubble);
         tick();
         e_exp = sb.pop_front(); e_obs = sample(); checks++;
         if (e_obs !== e_exp) begin
            errors++;
            $display("FAIL reset_hold%0d: got %h expected %h", i, e_obs, e_exp);
         end
      end
      checks++;
      if ({fwd_sel_rs, fwd_sel_rt} !== 4'd0) begin
         errors++;
         $display("FAIL reset_fwd_sel: got %b expected 0000", {fwd_sel_rs, fwd_sel_rt});
      end
`ifdef IDEX_BUBBLE_CNT_EN
      checks++;
      if (bubble_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt);
      end
`endif
      reset = 1'b0;
      drive_load(mk(32'h00221820, 32'h4, 32'd5, 32'd9, 32'h1820, 3'd0, 5'b00100, 5'd3));
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", e_obs, e_exp);
      end
   endtask

   task automatic test_mem_fwd();
      // rs=$1, rt=$2
      drive_load(mk(32'h00221820, 32'h8, 32'd7, 32'h22, 32'h0, 3'd1, 5'b00100, 5'd3));
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL mem_fwd_load: got %h expected %h", e_obs, e_exp);
      end
      m_we = 1'b1; m_waddr = 5'd1; m_wdata = 32'h1234;
      #1; checks++;
      if ({fwd_sel_rs, rs_out, fwd_sel_rt, rt_out} !== {2'd1, 32'h1234, 2'd0, 32'h22}) begin
         errors++;
         $display("FAIL mem_fwd_rs: got sel=%0d rs=%h sel_rt=%0d rt=%h expected 1 1234 0 22",
                  fwd_sel_rs, rs_out, fwd_sel_rt, rt_out);
      end
      w_we = 1'b1; w_waddr = 5'd1; w_wdata = 32'h99;
      #1; checks++;
      if ({fwd_sel_rs, rs_out} !== {2'd1, 32'h1234}) begin
         errors++;
         $display("FAIL mem_over_wb: got sel=%0d rs=%h expected 1 1234", fwd_sel_rs, rs_out);
      end
      m_we = 1'b0;
      #1; checks++;
      if ({fwd_sel_rs, rs_out} !== {2'd2, 32'h99}) begin
         errors++;
         $display("FAIL wb_fwd_rs: got sel=%0d rs=%h expected 2 99", fwd_sel_rs, rs_out);
      end
      w_waddr = 5'd2;
      #1; checks++;
      if ({fwd_sel_rs, rs_out, fwd_sel_rt, rt_out} !== {2'd0, 32'd7, 2'd2, 32'h99}) begin
         errors++;
         $display("FAIL wb_fwd_rt: got sel_rs=%0d rs=%h sel_rt=%0d rt=%h expected 0 7 2 99",
                  fwd_sel_rs, rs_out, fwd_sel_rt, rt_out);
      end
      clear_fwd();
   endtask

   task automatic test_zero_guard();
      // rs=$4, rt=$0
      drive_load(mk({6'd0, 5'd4, 5'd0, 5'd5, 11'd0}, 32'hC, 32'h4444, 32'h5555,
                    32'h0, 3'd2, 5'b00100, 5'd5));
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL zero_load: got %h expected %h", e_obs, e_exp);
      end
      m_we = 1'b1; m_waddr = 5'd0; m_wdata = 32'hFFFF;
      w_we = 1'b1; w_waddr = 5'd0; w_wdata = 32'hEEEE;
      #1; checks++;
      if ({fwd_sel_rt, rt_out} !== {2'd0, 32'h5555}) begin
         errors++;
         $display("FAIL zero_guard: got sel=%0d rt=%h expected 0 5555", fwd_sel_rt, rt_out);
      end
      clear_fwd();
   endtask

   task automatic test_stall_refresh();
      exp_t e;
      // rs=$6, rt=$3
      e = mk({6'd0, 5'd6, 5'd3, 5'd7, 11'h20}, 32'h10, 32'h2222, 32'h1111,
             32'h7, 3'd3, 5'b01110, 5'd7);
      drive_load(e);
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL stall_load: got %h expected %h", e_obs, e_exp);
      end
      stall = 1'b1;
      drive_rand();
      w_we = 1'b1; w_waddr = 5'd3; w_wdata = 32'hABCD;
      e.rt = 32'hABCD;
      sb.push_back(e);
      tick();
      w_we = 1'b0;
      #1; checks++;
      if ({fwd_sel_rt, rt_out} !== {2'd0, 32'hABCD}) begin
         errors++;
         $display("FAIL stall_refresh_rt: got sel=%0d rt=%h expected 0 abcd", fwd_sel_rt, rt_out);
      end
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL stall_hold: got %h expected %h", e_obs, e_exp);
      end
      stall = 1'b0;
      clear_fwd();
   endtask

   task automatic test_flush_stall();
      drive_load(mk(32'h00432020, 32'h100, 32'h1, 32'h2, 32'h3, 3'd5, 5'b11111, 5'd4));
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL flush_preload: got %h expected %h", e_obs, e_exp);
      end
      stall = 1'b1; flush = 1'b1;
      drive_rand();
      sb.push_back(c_bubble);
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL flush_over_stall: got %h expected %h", e_obs, e_exp);
      end
`ifdef IDEX_BUBBLE_CNT_EN
      checks++;
      if (bubble_cnt !== 32'd1) begin
         errors++;
         $display("FAIL bubble_cnt: got %0d expected 1", bubble_cnt);
      end
`endif
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive_load(mk(32'h00A51020 + 32'(i), 32'h200 + 32'(4 * i), 32'h30 + 32'(i),
                       32'h40 + 32'(i), 32'(i), 3'(i), 5'(i + 1), 5'(i + 8)));
         tick();
         e_exp = sb.pop_front(); e_obs = sample(); checks++;
         if (e_obs !== e_exp) begin
            errors++;
            $display("FAIL back_to_back%0d: got %h expected %h", i, e_obs, e_exp);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      stall = 1'b1; reset = 1'b1;
      drive_rand();
      sb.push_back(c_bubble);
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL reset_mid_stall: got %h expected %h", e_obs, e_exp);
      end
      stall = 1'b0; reset = 1'b0;
      drive_load(mk(32'h01095020, 32'h300, 32'h55, 32'h66, 32'h77, 3'd4, 5'b10101, 5'd10));
      tick();
      e_exp = sb.pop_front(); e_obs = sample(); checks++;
      if (e_obs !== e_exp) begin
         errors++;
         $display("FAIL resume_after_reset: got %h expected %h", e_obs, e_exp);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      clear_fwd();
      drive_rand();
      test_reset();
      test_mem_fwd();
      test_zero_guard();
      test_stall_refresh();
      test_flush_stall();
      test_back_to_back();
      test_reset_mid_stall();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
